// File: rtl/noc_hdr_pkg.sv
// Shared header-format definitions for the router header-detect stages.
package noc_hdr_pkg;

    localparam int HDR_W_DEF  = 6;
    localparam int ADDR_W_DEF = 2;

    // All-ones destination: broadcast address when broadcast matching is built in
    localparam logic [ADDR_W_DEF-1:0] BCAST_ADDR = '1;

    // Destination field sits in the low bits of the header
    function automatic logic [ADDR_W_DEF-1:0] dest_field(input logic [HDR_W_DEF-1:0] hdr);
        return hdr[ADDR_W_DEF-1:0];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after last_grant+1, wrapping.
// Purely combinational so callers decide when a grant is taken.
module rr_arbiter #(
    parameter  int NUM_PORTS = 4,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PW-1:0]        last_grant,
    output logic [NUM_PORTS-1:0] grant,
    output logic [PW-1:0]        grant_idx,
    output logic                 grant_valid
);

    int idx;

    // Scan ports in priority order starting just after the last winner
    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 1; k <= NUM_PORTS; k++) begin
            idx = (int'(last_grant) + k) % NUM_PORTS;
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = PW'(idx);
                grant[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hdr_match_arb.sv
// Header-detect stage: one header slot per input port; headers addressed to
// this router go to a single registered ejection output under round-robin,
// all others are offered on the port's pass-through output.
// Optional build macro: HDR_MATCH_BROADCAST_EN (all-ones destination also matches).
module hdr_match_arb
    import noc_hdr_pkg::*;
#(
    parameter  int NUM_PORTS = 4,
    parameter  int HDR_W     = HDR_W_DEF,
    parameter  int ADDR_W    = ADDR_W_DEF,
    localparam int PW        = $clog2(NUM_PORTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [ADDR_W-1:0]          local_addr,
    input  logic [NUM_PORTS-1:0]       in_valid,
    input  logic [NUM_PORTS*HDR_W-1:0] in_header,
    output logic [NUM_PORTS-1:0]       in_ready,
    output logic [NUM_PORTS-1:0]       match,
    output logic                       eject_valid,
    input  logic                       eject_ready,
    output logic [PW-1:0]              eject_port,
    output logic [HDR_W-1:0]           eject_header,
    output logic [NUM_PORTS-1:0]       pass_valid,
    input  logic [NUM_PORTS-1:0]       pass_ready,
    output logic [NUM_PORTS*HDR_W-1:0] pass_header
);

    logic [NUM_PORTS-1:0][HDR_W-1:0] slot_q, slot_d, hdr_in;
    logic [NUM_PORTS-1:0]            full_q, full_d;
    logic                            eject_valid_q, eject_valid_d;
    logic [HDR_W-1:0]                eject_header_q, eject_header_d;
    logic [PW-1:0]                   eject_port_q, eject_port_d;
    logic [PW-1:0]                   last_grant_q, last_grant_d;

    logic [NUM_PORTS-1:0] dest_hit, req, gnt, deq;
    logic [PW-1:0]        gnt_idx;
    logic                 gnt_valid;
    logic                 out_free;

    assign hdr_in = in_header;

    // Destination compare per slot, live against local_addr
    always_comb begin
        dest_hit = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            dest_hit[p] = ~|(slot_q[p][ADDR_W-1:0] ^ local_addr);
`ifdef HDR_MATCH_BROADCAST_EN
            dest_hit[p] = dest_hit[p] | (&slot_q[p][ADDR_W-1:0]);
`endif
        end
    end

    assign match      = full_q & dest_hit;
    assign pass_valid = full_q & ~dest_hit;
    assign out_free   = ~eject_valid_q | eject_ready;
    assign req        = out_free ? match : '0;

    rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_arb (
        .req         (req),
        .last_grant  (last_grant_q),
        .grant       (gnt),
        .grant_idx   (gnt_idx),
        .grant_valid (gnt_valid)
    );

    // A slot empties on ejection grant or on a pass-through handshake
    assign deq      = gnt | (pass_valid & pass_ready);
    assign in_ready = ~full_q | deq;

    // Slot fill/drain; a refill in the draining cycle keeps the slot full
    always_comb begin
        slot_d = slot_q;
        full_d = full_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (in_valid[p] && in_ready[p]) begin
                slot_d[p] = hdr_in[p];
                full_d[p] = 1'b1;
            end else if (deq[p]) begin
                full_d[p] = 1'b0;
            end
        end
    end

    // Output register: load on grant, drain when consumer takes it, else hold
    always_comb begin
        eject_valid_d  = eject_valid_q;
        eject_header_d = eject_header_q;
        eject_port_d   = eject_port_q;
        last_grant_d   = last_grant_q;
        if (out_free) begin
            if (gnt_valid) begin
                eject_valid_d  = 1'b1;
                eject_header_d = slot_q[gnt_idx];
                eject_port_d   = gnt_idx;
                last_grant_d   = gnt_idx;
            end else begin
                eject_valid_d  = 1'b0;
            end
        end
    end

    // State registers; last_grant resets to the top port so port 0 wins first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q         <= '0;
            full_q         <= '0;
            eject_valid_q  <= 1'b0;
            eject_header_q <= '0;
            eject_port_q   <= '0;
            last_grant_q   <= PW'(NUM_PORTS - 1);
        end else begin
            slot_q         <= slot_d;
            full_q         <= full_d;
            eject_valid_q  <= eject_valid_d;
            eject_header_q <= eject_header_d;
            eject_port_q   <= eject_port_d;
            last_grant_q   <= last_grant_d;
        end
    end

    assign eject_valid  = eject_valid_q;
    assign eject_header = eject_header_q;
    assign eject_port   = eject_port_q;
    assign pass_header  = slot_q;

endmodule
